rot_share_arb: RTL and testbench

Four-requester arbiter and sequencer that time-shares the team's single 8-bit combinational left/right rotator. Each requester presents an operand, a rotate amount and a direction over a valid/ready handshake. The block grants one requester per cycle, drives the shared rotator, and holds the result in a one-entry output register tagged with the requester ID. It sits between the client ports and the rotator datapath, so the rotator is never duplicated per client.

---
 rtl/rot_share_arb.sv | 93 +++++++++
 tb/tb_rot_share_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rot_share_arb.sv
// rot_share_arb: four requesters time-share one 8-bit rotator; define ROT_SHARE_RR_EN for round-robin, otherwise fixed priority
module rot_share_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_a,
  input  logic [11:0] req_amt,
  input  logic [3:0]  req_lr,
  output logic [3:0]  req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_id,
  input  logic        rsp_ready
);
  localparam int N_REQ = 4;
  localparam int DW = 8;
  logic [1:0] ptr;
  logic [1:0] cand;
  logic [1:0] gnt_id;
  logic found;
  logic grant;
  logic slot_free;
  logic [DW-1:0] a_sel;
  logic [2:0] amt_sel;
  logic lr_sel;
  logic [2*DW-1:0] shl;
  logic [2*DW-1:0] shr;
  logic [DW-1:0] rot_y;
  logic rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_id_q, rsp_id_d;
`ifdef ROT_SHARE_RR_EN
  logic [1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 2'd0;
`endif
  assign slot_free = !rsp_valid_q || rsp_ready;
  // pick the first valid requester searching upward from the pointer
  always_comb begin
    found = 1'b0;
    gnt_id = 2'd0;
    cand = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + i[1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt_id = cand;
      end
    end
    grant = found && slot_free && !reset;
    req_ready = grant ? 4'b0001 << gnt_id : 4'b0000;
  end
  // shared rotator driven by the granted requester's payload
  always_comb begin
    a_sel = req_a[gnt_id*DW +: DW];
    amt_sel = req_amt[gnt_id*3 +: 3];
    lr_sel = req_lr[gnt_id];
    shl = {a_sel, a_sel} << amt_sel;
    shr = {a_sel, a_sel} >> amt_sel;
    rot_y = lr_sel ? shr[DW-1:0] : shl[2*DW-1:DW];
  end
  // output slot: refill on grant, drain when consumed, otherwise hold
  always_comb begin
    rsp_valid_d = grant || (rsp_valid_q && !rsp_ready);
    rsp_data_d = grant ? rot_y : rsp_data_q;
    rsp_id_d = grant ? gnt_id : rsp_id_q;
  end
  // output slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q <= 2'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q <= rsp_id_d;
    end
  end
`ifdef ROT_SHARE_RR_EN
  // pointer moves just past the last winner
  always_comb ptr_d = grant ? gnt_id + 2'd1 : ptr_q;
  // round-robin pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 2'd0;
    else ptr_q <= ptr_d;
  end
`endif
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id = rsp_id_q;
endmodule

// File: tb/tb_rot_share_arb.sv
// tb_rot_share_arb: scoreboard bench with a behavioural model for rot_share_arb
module tb_rot_share_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_a = '0;
  logic [11:0] req_amt = '0;
  logic [3:0] req_lr = '0;
  logic [3:0] req_ready;
  logic rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_id;
  logic rsp_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];
  logic [3:0] pend = '0;
  logic [7:0] ma[4];
  logic [2:0] mamt[4];
  logic mlr[4];
  int ptr = 0;
  bit full = 0;

  rot_share_arb dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_amt(req_amt),
    .req_lr(req_lr), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] a, input logic [2:0] k, input logic lr);
    logic [7:0] y = a;
    repeat (k) y = lr ? {y[0], y[7:1]} : {y[6:0], y[7]};
    return y;
  endfunction

  task automatic apply();
    req_valid = pend;
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8] = ma[i];
      req_amt[3*i +: 3] = mamt[i];
      req_lr[i] = mlr[i];
    end
  endtask

  // one cycle of stimulus and model step; called right at a falling edge
  task automatic cycle(input bit rnd, input logic [3:0] fm, input logic [31:0] fa,
                       input logic [11:0] famt, input logic [3:0] flr, input bit rr);
    int g;
    for (int i = 0; i < 4; i++)
      if (!pend[i] && (rnd ? ($urandom_range(1, 0) == 1) : fm[i])) begin
        pend[i] = 1'b1;
        ma[i] = rnd ? 8'($urandom) : fa[8*i +: 8];
        mamt[i] = rnd ? 3'($urandom) : famt[3*i +: 3];
        mlr[i] = rnd ? 1'($urandom) : flr[i];
      end
    apply();
    rsp_ready = rnd ? ($urandom_range(9, 0) < 7) : rr;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(full));
    g = -1;
    if (!full || rsp_ready)
      for (int j = 0; j < 4; j++)
        if (g < 0 && pend[(ptr + j) % 4]) g = (ptr + j) % 4;
    chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    if (g >= 0) begin
      sb.push_back({2'(g), rot(ma[g], mamt[g], mlr[g])});
      pend[g] = 1'b0;
`ifdef ROT_SHARE_RR_EN
      ptr = (g + 1) % 4;
`endif
      full = 1;
    end else if (full && rsp_ready) full = 0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      cycle(0, 4'b0000, 32'd0, 12'd0, 4'd0, 1'b1);
    end
  endtask

  // monitor: compare each consumed response against the scoreboard head
  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    #3;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got id %0d data %0h want none", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[9:8]));
        chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      ma[i] = '0;
      mamt[i] = '0;
      mlr[i] = 1'b0;
    end
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 4'b1111, 32'h44332211, 12'o7531, 4'b0101, 1'b1);
    chk("first_grant", 32'(req_ready), 32'h1);
    repeat (4) begin
      @(negedge clk);
      cycle(0, 4'b1111, 32'h44332211, 12'o7531, 4'b0101, 1'b1);
    end
    drain(6);
    @(negedge clk);
    cycle(0, 4'b0100, 32'h0081_0000, 12'd3 << 6, 4'b0000, 1'b1);
    chk("single_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_data", 32'(rsp_data), 32'h0C);
    chk("single_id", 32'(rsp_id), 2);
    cycle(0, 4'b0001, 32'h0000_00A5, 12'd1, 4'b0001, 1'b1);
    @(negedge clk);
    chk("right_data", 32'(rsp_data), 32'hD2);
    cycle(0, 4'b0001, 32'h0000_003C, 12'd0, 4'b0000, 1'b1);
    @(negedge clk);
    chk("zero_amt_data", 32'(rsp_data), 32'h3C);
    cycle(0, 4'b0000, 32'd0, 12'd0, 4'd0, 1'b1);
    drain(4);
    repeat (4) begin
      @(negedge clk);
      cycle(0, 4'b0011, 32'h0000_C3E1, 12'o25, 4'b0010, 1'b0);
    end
    @(negedge clk);
    cycle(0, 4'b0011, 32'h0000_C3E1, 12'o25, 4'b0010, 1'b1);
    drain(4);
    repeat (6) begin
      @(negedge clk);
      cycle(0, 4'b1010, 32'h9F00_7E00, 12'o6040, 4'b1000, 1'b1);
    end
    drain(6);
    repeat (400) begin
      @(negedge clk);
      cycle(1, 4'b0000, 32'd0, 12'd0, 4'd0, 1'b0);
    end
    repeat (2) begin
      @(negedge clk);
      cycle(0, 4'b1111, 32'h8040_2010, 12'o1234, 4'b1100, 1'b0);
    end
    @(negedge clk);
    apply();
    chk("pre_reset_valid", 32'(rsp_valid), 1);
    #5 reset = 1'b1;
    #1;
    chk("mid_reset_valid", 32'(rsp_valid), 0);
    chk("mid_reset_data", 32'(rsp_data), 0);
    chk("mid_reset_id", 32'(rsp_id), 0);
    chk("mid_reset_ready", 32'(req_ready), 0);
    sb.delete();
    full = 0;
    ptr = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 4'b1111, 32'h8040_2010, 12'o1234, 4'b1100, 1'b1);
    chk("post_reset_grant", 32'(req_ready), 32'h1);
    drain(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
